// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between N_REQ requesters.
// A session lasts while the owner holds its req_ss line. Starts, tx data and
// word counts pass through to the master. Received bytes return to the owner.
// Chip selects are released only after the last outstanding word has arrived.
module spi_bus_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned WORDS_W    = 6,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_ss,
  input  logic [N_REQ-1:0]         req_en,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [WORDS_W*N_REQ-1:0] req_words,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         req_valid,
  output logic [7:0]               req_rx_data,
  output logic [N_REQ-1:0]         grant,
  output logic                     m_en,
  output logic [7:0]               m_data,
  output logic [WORDS_W-1:0]       m_words,
  input  logic                     m_ready,
  input  logic                     m_valid,
  input  logic [7:0]               m_rx_data,
  output logic [N_REQ-1:0]         ss_n
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, OWN, DRAIN, GAP} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   owner, owner_next;
  logic [IDX_W-1:0]   ptr, ptr_next;
  logic [WORDS_W-1:0] outstanding, outstanding_next;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_next;
  logic [N_REQ-1:0]   grant_next;

  logic               active;
  logic               ready_g;
  logic               load;
  logic               own_en;
  logic               own_ss;
  logic [7:0]         own_data;
  logic [WORDS_W-1:0] own_words;

  logic               found_hi, found_lo, leave;
  logic [IDX_W-1:0]   pick_hi, pick_lo;

  // Owner datapath: mux the owner's lanes to the master, track outstanding words
  always_comb begin
    own_data  = '0;
    own_words = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (grant[j]) begin
        own_data  = req_data[j*8 +: 8];
        own_words = req_words[j*WORDS_W +: WORDS_W];
      end
    end
    own_en  = |(req_en & grant);
    own_ss  = |(req_ss & grant);
    active  = (state == OWN) || (state == DRAIN);
    ready_g = (state == OWN) && m_ready && (outstanding == '0);
    load    = ready_g && own_en && (own_words != '0);

    outstanding_next = outstanding;
    if (load)
      outstanding_next = own_words;
    else if (m_valid && (outstanding != '0))
      outstanding_next = outstanding - WORDS_W'(1);

    m_en        = load;
    m_data      = own_data;
    m_words     = own_words;
    req_ready   = ready_g ? grant : '0;
    req_valid   = (m_valid && (outstanding != '0)) ? grant : '0;
    req_rx_data = active ? m_rx_data : '0;
  end

  // Session FSM: round-robin pick, release/drain handling, inter-session gap
  always_comb begin
    state_next   = state;
    owner_next   = owner;
    ptr_next     = ptr;
    gap_cnt_next = gap_cnt;
    leave        = 1'b0;

    // Circular search from ptr done as two linear passes: [ptr..N-1] wins over [0..ptr-1].
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!found_hi && req_ss[j] && (j >= 32'(ptr))) begin
        found_hi = 1'b1;
        pick_hi  = IDX_W'(j);
      end
      if (!found_lo && req_ss[j]) begin
        found_lo = 1'b1;
        pick_lo  = IDX_W'(j);
      end
    end

    unique case (state)
      IDLE: begin
        if (found_lo) begin
          state_next = OWN;
          owner_next = found_hi ? pick_hi : pick_lo;
        end
      end
      OWN: begin
        if (!own_ss) begin
          if ((outstanding == '0) && !load) leave = 1'b1;
          else state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_next == '0) leave = 1'b1;
      end
      GAP: begin
        gap_cnt_next = gap_cnt + GAP_W'(1);
        if (32'(gap_cnt) + 32'd1 >= GAP_CYCLES) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (leave) begin
      gap_cnt_next = '0;
      ptr_next     = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
      if (GAP_CYCLES == 0) state_next = IDLE;
      else state_next = GAP;
    end

    grant_next = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      grant_next[j] = ((state_next == OWN) || (state_next == DRAIN)) && (owner_next == IDX_W'(j));
    end
  end

  // State and registered grant/chip-select update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= '0;
      outstanding <= '0;
      gap_cnt     <= '0;
      grant       <= '0;
      ss_n        <= '1;
    end else begin
      state       <= state_next;
      owner       <= owner_next;
      ptr         <= ptr_next;
      outstanding <= outstanding_next;
      gap_cnt     <= gap_cnt_next;
      grant       <= grant_next;
      ss_n        <= ~grant_next;
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Testbench for spi_bus_arbiter: directed stimulus, a cycle model of the
// arbitration rules compared every cycle, plus hand-computed literal checks.
module tb_spi_bus_arbiter;

  localparam int N   = 2;
  localparam int W   = 6;
  localparam int GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    req_ss, req_en;
  logic [15:0]   req_data;
  logic [11:0]   req_words;
  logic          m_ready, m_valid;
  logic [7:0]    m_rx_data;
  logic [1:0]    req_ready, req_valid, grant, ss_n;
  logic [7:0]    req_rx_data, m_data;
  logic [W-1:0]  m_words;
  logic          m_en;

  // second instance built without a gap state
  logic [1:0]    b_ss;
  logic [1:0]    b_en    = 2'b00;
  logic [15:0]   b_data  = 16'h0000;
  logic [11:0]   b_words = 12'h000;
  logic          b_mready = 1'b1, b_mvalid = 1'b0;
  logic [7:0]    b_mrx   = 8'h00;
  logic [1:0]    b_ready, b_valid, b_grant, b_ssn;
  logic [7:0]    b_rx, b_mdata;
  logic [W-1:0]  b_mwords;
  logic          b_men;

  spi_bus_arbiter #(.N_REQ(N), .WORDS_W(W), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .req_ss(req_ss), .req_en(req_en), .req_data(req_data),
    .req_words(req_words), .req_ready(req_ready), .req_valid(req_valid),
    .req_rx_data(req_rx_data), .grant(grant), .m_en(m_en), .m_data(m_data),
    .m_words(m_words), .m_ready(m_ready), .m_valid(m_valid), .m_rx_data(m_rx_data),
    .ss_n(ss_n)
  );

  spi_bus_arbiter #(.N_REQ(N), .WORDS_W(W), .GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .rst(rst), .req_ss(b_ss), .req_en(b_en), .req_data(b_data),
    .req_words(b_words), .req_ready(b_ready), .req_valid(b_valid),
    .req_rx_data(b_rx), .grant(b_grant), .m_en(b_men), .m_data(b_mdata),
    .m_words(b_mwords), .m_ready(b_mready), .m_valid(b_mvalid), .m_rx_data(b_mrx),
    .ss_n(b_ssn)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int words_of(input int o);
    return int'(req_words[o*W +: W]);
  endfunction

  // Model state: owner index (-1 = none), draining flag, words still due,
  // gap cycles left before arbitration resumes, round-robin start point.
  int mo = -1, mout = 0, mgap = 0, mptr = 0;
  bit mdrain = 1'b0, started = 1'b0;

  always @(posedge clk) begin : model
    int o, n_out, n_gap, n_ptr;
    bit n_drain, ld;
    o = mo; n_out = mout; n_gap = mgap; n_ptr = mptr; n_drain = mdrain;
    if (rst) begin
      o = -1; n_out = 0; n_gap = 0; n_ptr = 0; n_drain = 1'b0;
    end else if (o < 0) begin
      if (n_gap > 0) n_gap = n_gap - 1;
      else begin
        for (int k = 0; k < N; k++)
          if (o < 0 && req_ss[(mptr + k) % N]) begin
            o = (mptr + k) % N;
            n_drain = 1'b0;
          end
      end
    end else begin
      ld = !mdrain && m_ready && (mout == 0) && req_en[o] && (words_of(o) != 0);
      if (ld) n_out = words_of(o);
      else if (m_valid && mout > 0) n_out = mout - 1;
      if ((!mdrain && !req_ss[o] && mout == 0 && !ld) || (mdrain && n_out == 0)) begin
        n_ptr = (o + 1) % N;
        o = -1;
        n_gap = GAP;
        n_drain = 1'b0;
      end else if (!mdrain && !req_ss[o]) begin
        n_drain = 1'b1;
      end
    end
    mo <= o; mout <= n_out; mgap <= n_gap; mptr <= n_ptr; mdrain <= n_drain;
    started <= 1'b1;
  end

  always @(negedge clk) begin : compare
    logic [1:0] eg, ess, erdy, evl;
    logic       emen;
    logic [7:0] ed;
    logic [W-1:0] ew;
    if (started) begin
      eg   = (mo >= 0) ? 2'(1 << mo) : 2'b00;
      ess  = ~eg;
      erdy = (mo >= 0 && !mdrain && m_ready && mout == 0) ? eg : 2'b00;
      emen = (erdy != 2'b00) && req_en[mo] && (words_of(mo) != 0);
      evl  = (mo >= 0 && m_valid && mout > 0) ? eg : 2'b00;
      ed   = (mo >= 0) ? req_data[mo*8 +: 8] : 8'h00;
      ew   = (mo >= 0) ? W'(words_of(mo)) : '0;
      chk("m_grant", grant, eg);
      chk("m_ss_n", ss_n, ess);
      chk("m_req_ready", req_ready, erdy);
      chk("m_req_valid", req_valid, evl);
      chk("m_en", m_en, emen);
      chk("m_data", m_data, ed);
      chk("m_words", m_words, ew);
      if (evl != 2'b00) chk("m_rx_data", req_rx_data, m_rx_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_ss = '0; req_en = '0; req_data = '0; req_words = '0;
    m_ready = 1'b1; m_valid = 1'b0; m_rx_data = '0; b_ss = '0;
    cyc(); cyc();
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_ss_n", ss_n, 2'b11);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_m_en", m_en, 1'b0);

    // single requester transaction
    cyc(); rst = 1'b0; req_ss = 2'b01; #2;
    chk("grant_latency", grant, 2'b00);
    cyc(); #2;
    chk("single_grant", grant, 2'b01);
    chk("single_ss_n", ss_n, 2'b10);
    chk("single_ready", req_ready, 2'b01);
    req_en = 2'b01; req_data[7:0] = 8'hD0; req_words[5:0] = 6'd2; #1;
    chk("single_m_en", m_en, 1'b1);
    chk("single_m_data", m_data, 8'hD0);
    chk("single_m_words", m_words, 6'd2);
    cyc(); req_en = 2'b00; m_valid = 1'b1; m_rx_data = 8'h00; #2;
    chk("busy_ready", req_ready, 2'b00);
    chk("rx1_valid", req_valid, 2'b01);
    cyc(); m_rx_data = 8'h58; #2;
    chk("rx2_valid", req_valid, 2'b01);
    chk("rx2_data", req_rx_data, 8'h58);
    cyc(); m_rx_data = 8'hAA; #2;
    chk("stray_valid", req_valid, 2'b00);
    cyc(); m_valid = 1'b0; req_en = 2'b10; req_words[11:6] = 6'd3; #2;
    chk("non_owner_en", m_en, 1'b0);
    cyc(); req_en = 2'b01; req_words[5:0] = 6'd0; #2;
    chk("zero_words_en", m_en, 1'b0);
    chk("zero_words_ready", req_ready, 2'b01);
    cyc(); req_en = 2'b00; #2;
    chk("zero_words_noload", req_ready, 2'b01);
    req_ss = 2'b00;
    cyc(); #2;
    chk("gap1_ss_n", ss_n, 2'b11);
    chk("gap1_grant", grant, 2'b00);
    cyc(); #2;
    chk("gap2_ss_n", ss_n, 2'b11);
    cyc();

    // contention straight out of reset, then round robin
    rst = 1'b1; req_ss = 2'b11;
    cyc(); cyc(); rst = 1'b0; #2;
    chk("cont_latency", grant, 2'b00);
    cyc(); #2;
    chk("cont_first", grant, 2'b01);
    req_ss = 2'b10;
    cyc(); #2;
    chk("cont_gap1", ss_n, 2'b11);
    cyc(); #2;
    chk("cont_gap2", ss_n, 2'b11);
    cyc(); #2;
    chk("cont_idle", grant, 2'b00);
    cyc(); #2;
    chk("cont_second", grant, 2'b10);
    req_ss = 2'b01;
    repeat (4) cyc();
    #2;
    chk("cont_third", grant, 2'b01);
    req_ss = 2'b10;
    repeat (4) cyc();
    #2;
    chk("cont_fourth", grant, 2'b10);

    // early release while words are outstanding
    req_en = 2'b10; req_data[15:8] = 8'hA5; req_words[11:6] = 6'd2; #1;
    chk("early_m_en", m_en, 1'b1);
    chk("early_m_data", m_data, 8'hA5);
    cyc(); req_en = 2'b00; req_ss = 2'b00; #2;
    chk("early_busy", req_ready, 2'b00);
    cyc(); #2;
    chk("drain_ss_n", ss_n, 2'b01);
    chk("drain_grant", grant, 2'b10);
    chk("drain_ready", req_ready, 2'b00);
    m_valid = 1'b1; m_rx_data = 8'h11; #1;
    chk("drain_rx1", req_valid, 2'b10);
    cyc(); m_rx_data = 8'h22; #2;
    chk("drain_rx2", req_valid, 2'b10);
    chk("drain_rx2_ss_n", ss_n, 2'b01);
    chk("drain_rx2_data", req_rx_data, 8'h22);
    cyc(); m_valid = 1'b0; #2;
    chk("drain_gap1", ss_n, 2'b11);
    cyc(); #2;
    chk("drain_gap2", ss_n, 2'b11);
    cyc(); #2;
    chk("drain_idle", grant, 2'b00);

    // reset in the middle of a transfer restores ptr to 0
    req_ss = 2'b01;
    cyc(); #2;
    chk("mid_grant0", grant, 2'b01);
    req_ss = 2'b10;
    repeat (4) cyc();
    #2;
    chk("mid_grant1", grant, 2'b10);
    req_en = 2'b10; req_words[11:6] = 6'd1;
    cyc(); req_en = 2'b00; rst = 1'b1; #2;
    chk("mid_busy", req_ready, 2'b00);
    cyc(); #2;
    chk("mid_rst_grant", grant, 2'b00);
    chk("mid_rst_ss_n", ss_n, 2'b11);
    rst = 1'b0; req_ss = 2'b11;
    cyc(); #2;
    chk("mid_rst_ptr", grant, 2'b01);
    m_ready = 1'b0; #1;
    chk("master_busy", req_ready, 2'b00);
    m_ready = 1'b1; req_ss = 2'b00;
    repeat (4) cyc();

    // no-gap build: release goes straight to IDLE
    b_ss = 2'b11;
    cyc(); #2;
    chk("nogap_first", b_grant, 2'b01);
    b_ss = 2'b10;
    cyc(); #2;
    chk("nogap_idle_grant", b_grant, 2'b00);
    chk("nogap_idle_ss_n", b_ssn, 2'b11);
    cyc(); #2;
    chk("nogap_regrant", b_grant, 2'b10);
    chk("nogap_regrant_ss_n", b_ssn, 2'b01);
    b_ss = 2'b00;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
